// File: rtl/x_multdiv_ctrl.sv
// Execute-stage iterative signed multiply/divide unit. Captures the D/X operands,
// stalls the front of the pipeline for 32 iterations and strobes one result to X/M.
module x_multdiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic [WIDTH-1:0] in_ir,
  output logic             stall,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_ir,
  output logic             out_exception
);

  localparam int             CW     = $clog2(ITER + 1);
  localparam logic [CW-1:0]  LAST   = CW'(ITER - 1);
  localparam logic [4:0]     OP_MUL = 5'b00110;
  localparam logic [4:0]     OP_DIV = 5'b00111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    busy_q, out_valid_q, out_exc_q;
  logic [WIDTH-1:0]        out_result_q, out_ir_q, ir_q;
  logic                    is_div_q, neg_q, dz_q;
  logic [WIDTH-1:0]        a_q;
  logic [2*WIDTH-1:0]      b_q, acc_q;

  logic                    start, is_div_start;
  logic [WIDTH:0]          rem_sh, diff;
  logic [WIDTH-1:0]        a_d;
  logic [2*WIDTH-1:0]      b_d, acc_d;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0]        res_d;
  logic                    exc_d;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : v;
  endfunction

  // Product fits in WIDTH bits only when the upper half plus sign bit are all equal.
  function automatic logic ovf(input logic signed [2*WIDTH-1:0] p);
    return !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
  endfunction

  always_comb begin
    start        = in_valid && (in_ir[31:27] == 5'b00000) &&
                   ((in_ir[6:2] == OP_MUL) || (in_ir[6:2] == OP_DIV));
    is_div_start = (in_ir[6:2] == OP_DIV);

    rem_sh = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_q[WIDTH-1:0]};
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    if (is_div_q) begin
      // Restoring step: dividend bits shift into the remainder, quotient bits shift into a_q.
      if (!diff[WIDTH]) begin
        acc_d = {{(WIDTH-1){1'b0}}, diff};
        a_d   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {{(WIDTH-1){1'b0}}, rem_sh};
        a_d   = {a_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = a_q[0] ? acc_q + b_q : acc_q;
      b_d   = b_q << 1;
      a_d   = a_q >> 1;
    end

    prod_s = neg_q ? -$signed(acc_d) : $signed(acc_d);
    quo_s  = neg_q ? -$signed(a_d)   : $signed(a_d);
    if (is_div_q) begin
      res_d = dz_q ? '0 : quo_s;
      exc_d = dz_q;
    end else begin
      res_d = prod_s[WIDTH-1:0];
      exc_d = ovf(prod_s);
    end

    stall = (state_q == S_BUSY) || ((state_q == S_IDLE) && start);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_exc_q    <= 1'b0;
      out_result_q <= '0;
      out_ir_q     <= '0;
      ir_q         <= '0;
      is_div_q     <= 1'b0;
      neg_q        <= 1'b0;
      dz_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_valid_q <= 1'b0;
          if (start) begin
            state_q  <= S_BUSY;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            ir_q     <= in_ir;
            is_div_q <= is_div_start;
            neg_q    <= in_A[WIDTH-1] ^ in_B[WIDTH-1];
            dz_q     <= (in_B == '0);
            acc_q    <= '0;
            // Divide keeps the dividend in a_q; multiply keeps the multiplier there.
            a_q      <= is_div_start ? mag(in_A) : mag(in_B);
            b_q      <= {{WIDTH{1'b0}}, (is_div_start ? mag(in_B) : mag(in_A))};
          end
        end
        S_BUSY: begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b1;
            out_result_q <= res_d;
            out_exc_q    <= exc_d;
            out_ir_q     <= ir_q;
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_ir        = out_ir_q;
  assign out_exception = out_exc_q;

endmodule

// File: tb/tb_x_multdiv_ctrl.sv
// Randomised bench for x_multdiv_ctrl: directed corner operations plus random
// operations compared against a 64-bit arithmetic reference model.
module tb_x_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_A = '0, in_B = '0, in_ir = '0;
  logic        stall, busy, out_valid, out_exception;
  logic [31:0] out_result, out_ir;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_res = '0, last_ir = '0;
  logic        last_exc = 1'b0;

  x_multdiv_ctrl #(.WIDTH(32), .ITER(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_A(in_A), .in_B(in_B), .in_ir(in_ir),
    .stall(stall), .busy(busy), .out_valid(out_valid),
    .out_result(out_result), .out_ir(out_ir), .out_exception(out_exception)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [4:0] alu);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = opc;
    r[6:2]   = alu;
    return r;
  endfunction

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 200));
      6: return 32'(-int'($urandom_range(1, 200)));
      default: return $urandom;
    endcase
  endfunction

  // Reference: exact signed arithmetic in 64 bits, then the result rules applied.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ir,
                                 output logic [31:0] r, output logic e);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (ir[6:2] == 5'b00111) begin
      if (b == 32'h0) begin
        r = 32'h0;
        e = 1'b1;
      end else begin
        p = sa / sb;
        r = p[31:0];
        e = 1'b0;
      end
    end else begin
      p = sa * sb;
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end
  endfunction

  task automatic scramble();
    in_valid = 1'($urandom_range(0, 1));
    in_A     = $urandom;
    in_B     = $urandom;
    in_ir    = mk_ir($urandom_range(0, 1) ? 5'b00000 : 5'($urandom),
                     $urandom_range(0, 1) ? 5'b00110 : 5'b00111);
  endtask

  // Issues one mul/div in the cycle after the call and checks it to its DONE cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ir, input bit hold);
    logic [31:0] er;
    logic        ee;
    ref_op(a, b, ir, er, ee);
    tick();
    check({tag, ".prev_valid"}, 32'(out_valid), 32'h0);
    check({tag, ".held_res"}, out_result, last_res);
    in_valid = 1'b1;
    in_A = a;
    in_B = b;
    in_ir = ir;
    #1;
    check({tag, ".stall_T"}, 32'(stall), 32'h1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (!hold) scramble();
      #1;
      check($sformatf("%s.stall_T+%0d", tag, k), 32'(stall), 32'h1);
      check($sformatf("%s.busy_T+%0d", tag, k), 32'(busy), 32'h1);
      check($sformatf("%s.valid_T+%0d", tag, k), 32'(out_valid), 32'h0);
    end
    tick();
    if (!hold) scramble();
    #1;
    check({tag, ".valid"}, 32'(out_valid), 32'h1);
    check({tag, ".stall_done"}, 32'(stall), 32'h0);
    check({tag, ".busy_done"}, 32'(busy), 32'h0);
    check({tag, ".result"}, out_result, er);
    check({tag, ".exc"}, 32'(out_exception), 32'(ee));
    check({tag, ".ir"}, out_ir, ir);
    last_res = er;
    last_ir  = ir;
    last_exc = ee;
  endtask

  task automatic idle_run(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      in_valid = 1'($urandom_range(0, 1));
      in_A = $urandom;
      in_B = $urandom;
      in_ir = in_valid ? mk_ir(5'b00101, 5'b00110) : mk_ir(5'b00000, 5'b00110);
      #1;
      check({tag, ".stall"}, 32'(stall), 32'h0);
      check({tag, ".valid"}, 32'(out_valid), 32'h0);
    end
  endtask

  localparam logic [4:0] MUL = 5'b00110;
  localparam logic [4:0] DIV = 5'b00111;

  initial begin
    reset = 1'b0;
    tick();
    tick();
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.stall", 32'(stall), 32'h0);
    check("rst.valid", 32'(out_valid), 32'h0);
    check("rst.result", out_result, 32'h0);
    check("rst.ir", out_ir, 32'h0);
    check("rst.exc", 32'(out_exception), 32'h0);
    reset = 1'b1;

    run_op("mul_7x-3", 32'd7, 32'hFFFFFFFD, mk_ir(5'b00000, MUL), 1'b0);
    check("mul_7x-3.const", out_result, 32'hFFFFFFEB);
    run_op("mul_ovf", 32'h00010000, 32'h00010000, mk_ir(5'b00000, MUL), 1'b0);
    check("mul_ovf.const", 32'(out_exception), 32'h1);
    run_op("mul_m1m1", 32'hFFFFFFFF, 32'hFFFFFFFF, mk_ir(5'b00000, MUL), 1'b0);
    check("mul_m1m1.const", out_result, 32'h00000001);
    run_op("div_-7/2", 32'hFFFFFFF9, 32'd2, mk_ir(5'b00000, DIV), 1'b0);
    check("div_-7/2.const", out_result, 32'hFFFFFFFD);
    run_op("div_100/-7", 32'd100, 32'hFFFFFFF9, mk_ir(5'b00000, DIV), 1'b0);
    check("div_100/-7.const", out_result, 32'hFFFFFFF2);
    run_op("div_5/0", 32'd5, 32'd0, mk_ir(5'b00000, DIV), 1'b0);
    check("div_5/0.const", 32'(out_exception), 32'h1);
    run_op("div_min/-1", 32'h80000000, 32'hFFFFFFFF, mk_ir(5'b00000, DIV), 1'b0);
    check("div_min/-1.const", out_result, 32'h80000000);

    run_op("b2b_mul", 32'h12345, 32'hFFFF0001, mk_ir(5'b00000, MUL), 1'b1);
    run_op("b2b_div", 32'h7FFFFFFF, 32'd3, mk_ir(5'b00000, DIV), 1'b1);

    idle_run("nonop", 12);

    // Reset in the middle of a multiply.
    tick();
    in_valid = 1'b1;
    in_A = 32'd5;
    in_B = 32'd6;
    in_ir = mk_ir(5'b00000, MUL);
    #1;
    check("rstmid.stall_T", 32'(stall), 32'h1);
    for (int k = 1; k <= 10; k++) tick();
    reset = 1'b0;
    in_valid = 1'b0;
    tick();
    check("rstmid.busy", 32'(busy), 32'h0);
    check("rstmid.stall", 32'(stall), 32'h0);
    check("rstmid.valid", 32'(out_valid), 32'h0);
    check("rstmid.result", out_result, 32'h0);
    check("rstmid.ir", out_ir, 32'h0);
    check("rstmid.exc", 32'(out_exception), 32'h0);
    reset = 1'b1;
    last_res = '0;
    last_ir  = '0;
    last_exc = 1'b0;
    idle_run("rstmid.after", 30);
    run_op("rstmid.new_mul", 32'hFFFFFF00, 32'd77, mk_ir(5'b00000, MUL), 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rand%0d", i), pick_opnd(), pick_opnd(),
             mk_ir(5'b00000, $urandom_range(0, 1) ? MUL : DIV), 1'($urandom_range(0, 1)));
      idle_run($sformatf("gap%0d", i), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
